// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// sources, with a post-reset clear sequence. Optional stats: define REGARB_STATS_EN.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic              we3,
  output logic [AW-1:0]     wa3,
  output logic [DW-1:0]     wd3,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic [NREQ-1:0] grant;
  logic            accept;
  int              cand;

  // Grant search: first valid requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    grant  = '0;
    win    = '0;
    accept = 1'b0;
    cand   = 0;
    idx    = '0;
    if (state_q == RUN && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NREQ) cand = cand - NREQ;
        idx = PW'(cand);
        if (!accept && req_valid[idx]) begin
          accept     = 1'b1;
          win        = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign busy      = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_cnt == '1) state_d = RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt <= '0;
      ptr     <= '0;
      we3     <= 1'b0;
      wa3     <= '0;
      wd3     <= '0;
    end else if (state_q == CLEAR) begin
      we3     <= 1'b1;
      wa3     <= clr_cnt;
      wd3     <= '0;
      clr_cnt <= clr_cnt + AW'(1);
    end else if (accept) begin
      ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      wa3 <= req_addr[int'(win)*AW +: AW];
      wd3 <= req_data[int'(win)*DW +: DW];
      // Register 0 is hardwired; the write is consumed but never issued.
      we3 <= (req_addr[int'(win)*AW +: AW] != '0);
    end else begin
      we3 <= 1'b0;
    end
  end

`ifdef REGARB_STATS_EN
  logic [15:0] conflict_q;
  logic        multi;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi = |(req_valid & (req_valid - NREQ'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_q <= '0;
    else if (state_q == RUN && multi && conflict_q != 16'hFFFF)
      conflict_q <= conflict_q + 16'd1;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (default parameters).
module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              hold;
  logic              we3;
  logic [AW-1:0]     wa3;
  logic [DW-1:0]     wd3;
  logic              busy;
  logic [15:0]       conflict_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .we3(we3),
    .wa3(wa3), .wd3(wd3), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we3"},  32'(we3), 32'd0);
    check({tag, "_wa3"},  32'(wa3), 32'd0);
    check({tag, "_wd3"},  wd3, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_rdy"},  32'(req_ready), 32'd0);
    check({tag, "_cnt"},  32'(conflict_cnt), 32'd0);
  endtask

  task automatic run_clear(input int last);
    for (int i = 0; i <= last; i++) begin
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_rdy", 32'(req_ready), 32'd0);
      tick();
      check("clr_we3", 32'(we3), 32'd1);
      check("clr_wa3", 32'(wa3), 32'(i));
      check("clr_wd3", wd3, 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    set_req(0, 5'd1, 32'hAAAA_0001);
    set_req(1, 5'd2, 32'hBBBB_0002);
    set_req(2, 5'd3, 32'hCCCC_0003);
    tick(); tick();
    check_reset_outputs("rst");

    // Clear sequence with all requesters pending.
    reset = 1'b0;
    run_clear(31);
    check("run_busy", 32'(busy), 32'd0);
    check("run_rdy", 32'(req_ready), 32'b001);
    req_valid = 3'b000;
    #1;

    // Single request from requester 1.
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1 check("single_rdy", 32'(req_ready), 32'b010);
    tick();
    req_valid = 3'b000;
    check("single_we3", 32'(we3), 32'd1);
    check("single_wa3", 32'(wa3), 32'd7);
    check("single_wd3", wd3, 32'hDEAD_BEEF);

    // Write to r0 from requester 2: accepted, discarded, ptr wraps to 0.
    set_req(2, 5'd0, 32'd5);
    req_valid = 3'b100;
    #1 check("r0_rdy", 32'(req_ready), 32'b100);
    tick();
    check("r0_we3", 32'(we3), 32'd0);

    // Round robin, all valid continuously.
    set_req(0, 5'd1, 32'h1111_0000);
    set_req(1, 5'd2, 32'h2222_0000);
    set_req(2, 5'd3, 32'h3333_0000);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_rdy", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      check("rr_we3", 32'(we3), 32'd1);
      check("rr_wa3", 32'(wa3), 32'((k % 3) + 1));
      check("rr_wd3", wd3, 32'((k % 3) + 1) * 32'h1111_0000);
    end
    req_valid = 3'b000;

    // Hold blocks grants; outputs keep last address.
    set_req(0, 5'd9, 32'h0000_0099);
    hold = 1'b1;
    req_valid = 3'b001;
    for (int k = 0; k < 3; k++) begin
      #1 check("hold_rdy", 32'(req_ready), 32'd0);
      tick();
      check("hold_we3", 32'(we3), 32'd0);
    end
    check("hold_wa3", 32'(wa3), 32'd3);
    hold = 1'b0;
    #1 check("unhold_rdy", 32'(req_ready), 32'b001);
    tick();
    req_valid = 3'b000;
    check("unhold_we3", 32'(we3), 32'd1);
    check("unhold_wa3", 32'(wa3), 32'd9);
    check("unhold_wd3", wd3, 32'h0000_0099);
    tick();
    check("idle_we3", 32'(we3), 32'd0);
    check("idle_wa3", 32'(wa3), 32'd9);

    // Reset in RUN with an accepted write on the port.
    set_req(0, 5'd20, 32'h5A5A_5A5A);
    req_valid = 3'b001;
    tick();
    check("pend_we3", 32'(we3), 32'd1);
    reset = 1'b1;
    #1 check_reset_outputs("rst_run");
    req_valid = 3'b000;
    tick();
    reset = 1'b0;

    // Reset during clear at wa3 = 12, then full clear from 0.
    run_clear(12);
    reset = 1'b1;
    #1 check_reset_outputs("rst_clr");
    tick();
    reset = 1'b0;
    run_clear(31);
    check("run2_busy", 32'(busy), 32'd0);

    // Contention statistic.
    hold = 1'b1;
    req_valid = 3'b011;
    for (int k = 0; k < 10; k++) tick();
    check("stat_rdy", 32'(req_ready), 32'd0);
`ifdef REGARB_STATS_EN
    check("stat_cnt10", 32'(conflict_cnt), 32'd10);
    for (int k = 0; k < 65525; k++) @(posedge clk);
    #1 check("stat_sat", 32'(conflict_cnt), 32'hFFFF);
    tick(); tick(); tick();
    check("stat_hold_sat", 32'(conflict_cnt), 32'hFFFF);
`else
    check("stat_off", 32'(conflict_cnt), 32'd0);
`endif
    req_valid = 3'b000;
    hold = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port (`we3`/`wa3`/`wd3`) of the 32×32 register file among `NREQ` writeback requesters, such as the ALU writeback, the load unit and the coprocessor. Arbitration is round-robin with a valid/ready handshake, and the port outputs are registered. After every reset the block also runs a clear sequence that writes zero to every register, because the register file itself has no reset. It sits between the writeback sources and the register file.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `AW`, 5: register address width; the register count is 2^AW.
- `DW`, 32: data width.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: requester i has a pending write.
- `req_addr` in NREQ*AW: destination of requester i at bits [i*AW +: AW].
- `req_data` in NREQ*DW: data of requester i at bits [i*DW +: DW].
- `req_ready` out NREQ: combinational one-hot grant; the request is accepted on the edge where valid&ready.
- `hold` in 1: pipeline stall; blocks new grants while in RUN.
- `we3` out 1: register-file write enable (registered).
- `wa3` out AW: register-file write address (registered).
- `wd3` out DW: register-file write data (registered).
- `busy` out 1: high while the clear sequence runs.
- `conflict_cnt` out 16: contention statistic (see Configuration).

## Operation
- FSM states: CLEAR and RUN. Reset forces CLEAR.
- **CLEAR:**
  - `clr_cnt` (AW bits) starts at 0.
  - Each edge registers `we3`=1, `wa3`=`clr_cnt`, `wd3`=0, then increments `clr_cnt`.
  - On the edge that issues `clr_cnt`=2^AW−1, the FSM moves to RUN.
  - `req_ready`=0 and `busy`=1 throughout; `hold` is ignored.
- **RUN, grant selection:**
  - `busy`=0.
  - If `hold`=0 and any `req_valid` is set, grant the first valid requester searching upward from `ptr`, wrapping modulo NREQ.
  - `req_ready` is one-hot on the winner, or all zero.
- **RUN, on an accepting edge (winner i):**
  - `ptr` <= (i+1) mod NREQ.
  - `wa3` <= `req_addr[i]`, `wd3` <= `req_data[i]`.
  - `we3` <= 1, unless `req_addr[i]`=0. A write to register 0 is accepted and discarded: `we3` <= 0, and `ptr` still advances.
- **RUN, on a non-accepting edge:**
  - `we3` <= 0; `wa3`/`wd3` keep their last values.
  - `ptr` is unchanged.
- Requesters hold `req_addr`/`req_data` stable while valid and not ready. The arbiter does not buffer unaccepted requests.

## Timing
- Reset values:
  - `we3`=0, `wa3`=0, `wd3`=0.
  - `req_ready`=0, `busy`=1, `conflict_cnt`=0.
  - `ptr`=0, `clr_cnt`=0, state=CLEAR.
- Clear sequence:
  - The first edge after reset release registers `we3`=1, `wa3`=0.
  - The 2^AW edges (32 by default) cover registers 0..31 in order.
  - `busy` falls and `req_ready` may assert in the cycle after the final clear issue.
- Latency:
  - Acceptance on edge N gives `we3`/`wa3`/`wd3` visible after edge N.
  - The register file captures the write on edge N+1.
  - Sustained throughput is one write per cycle.
- `hold` is sampled combinationally: `hold`=1 forces `req_ready`=0 in the same cycle.
- Reset mid-operation is immediate and asynchronous:
  - A request accepted but not yet written is lost.
  - The clear sequence restarts at register 0.
- Same-cycle requests to the same register from two requesters are serialized in round-robin order. The later grant's data is the final value.

## Configuration
- Macro: `REGARB_STATS_EN`.
- **Defined:**
  - `conflict_cnt` increments on every RUN edge where two or more `req_valid` bits are set, regardless of `hold`.
  - It saturates at 16'hFFFF and clears only on reset.
- **Undefined:**
  - No counter logic is present.
  - `conflict_cnt` is tied to 16'h0000.

## Test plan
- **Clear sequence:** release reset with `req_valid`=3'b111.
  - `we3`=1 with `wa3`=0..31 on 32 consecutive cycles, `wd3`=0.
  - `busy`=1 and `req_ready`=0 throughout.
  - Next cycle: `busy`=0 and `req_ready`=3'b001.
- **Single request:** requester 1 writes r7 = 0xDEADBEEF.
  - `req_ready`=3'b010 in the same cycle.
  - One cycle later: `we3`=1, `wa3`=7, `wd3`=0xDEADBEEF.
- **Round-robin:** all three requesters valid continuously, to r1/r2/r3.
  - Grants go 0,1,2,0,1,2 with no idle cycles.
  - `wa3` sequence is 1,2,3,1,2,3.
- **Register 0 and hold:**
  - Requester 2 writes r0 = 5: accepted, next `we3`=0, `ptr`=0.
  - Then `hold`=1 with requester 0 valid: `req_ready`=0 and `we3`=0 until `hold` falls.
- **Reset mid-operation:** assert reset during clear at `wa3`=12, and again in RUN with a write pending.
  - Outputs return to reset values immediately.
  - The clear restarts at `wa3`=0.
  - The pending write never appears.
- **Stats (`REGARB_STATS_EN`):**
  - 10 RUN cycles with two requesters valid give `conflict_cnt`=10.
  - Forcing near saturation, it holds at 0xFFFF.
  - Without the macro, it stays 0.
